freq_meter: RTL

Edge-counting frequency meter that sits directly downstream of the clock divider. It counts rising edges of an asynchronous input `sig_in` over the gate window bounded by consecutive `gate_tick` pulses from the divider. At each window close it publishes the count with a valid/ack handshake. An optional band comparison classifies the measured frequency for the eliminator logic downstream.

---
 rtl/freq_meter_if.sv | 33 +++
 rtl/freq_meter.sv | 129 ++++++++++++
 2 files changed

// File: rtl/freq_meter_if.sv
// rtl/freq_meter_if.sv - result handshake bundle for freq_meter; band ports exist only with FREQ_METER_BAND_EN
interface freq_meter_if #(
    parameter int CNT_W = 16
);
    logic [CNT_W-1:0] freq_out;
    logic             freq_valid;
    logic             freq_ack;
    logic             overflow;
    logic             overrun;
`ifdef FREQ_METER_BAND_EN
    logic [CNT_W-1:0] band_lo;
    logic [CNT_W-1:0] band_hi;
    logic             in_band;

    modport master (
        output freq_out, freq_valid, overflow, overrun, in_band,
        input  freq_ack, band_lo, band_hi
    );
    modport slave (
        input  freq_out, freq_valid, overflow, overrun, in_band,
        output freq_ack, band_lo, band_hi
    );
`else
    modport master (
        output freq_out, freq_valid, overflow, overrun,
        input  freq_ack
    );
    modport slave (
        input  freq_out, freq_valid, overflow, overrun,
        output freq_ack
    );
`endif
endinterface

// File: rtl/freq_meter.sv
// rtl/freq_meter.sv - gated rising-edge counter with valid/ack result
// Optional band classification of the result is built when FREQ_METER_BAND_EN is defined.
module freq_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         gate_tick,
    input  logic         sig_in,
    freq_meter_if.master res
);
    typedef enum logic {ST_WAIT, ST_COUNT} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   rise;
    logic [CNT_W-1:0]       cnt_q, cnt_d, res_cnt;
    logic                   sat_q, sat_d, res_sat;
    logic                   load;
    logic [CNT_W-1:0]       out_q;
    logic                   valid_q, ovf_q, ovr_q;

    assign rise = sync_q[SYNC_STAGES-1] & ~hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    // res_cnt/res_sat include an edge landing on the closing tick cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        res_cnt = cnt_q;
        res_sat = sat_q;
        load    = 1'b0;
        if (rise) begin
            res_cnt = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + CNT_ONE;
            res_sat = sat_q | (cnt_q == CNT_MAX);
        end
        case (state_q)
            ST_WAIT: begin
                if (gate_tick) begin
                    state_d = ST_COUNT;
                    cnt_d   = '0;
                    sat_d   = 1'b0;
                end
            end
            ST_COUNT: begin
                if (gate_tick) begin
                    load  = 1'b1;
                    cnt_d = '0;
                    sat_d = 1'b0;
                end else begin
                    cnt_d = res_cnt;
                    sat_d = res_sat;
                end
            end
            default: state_d = ST_WAIT;
        endcase
    end

    // A load coinciding with ack is a clean handoff, not an overwrite
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            if (load) begin
                out_q <= res_cnt;
                ovf_q <= res_sat;
            end
            if (load) begin
                valid_q <= 1'b1;
            end else if (res.freq_ack) begin
                valid_q <= 1'b0;
            end
            if (load && valid_q && !res.freq_ack) begin
                ovr_q <= 1'b1;
            end else if (res.freq_ack && valid_q) begin
                ovr_q <= 1'b0;
            end
        end
    end

`ifdef FREQ_METER_BAND_EN
    logic in_band_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in_band_q <= 1'b0;
        end else if (load) begin
            in_band_q <= (res_cnt >= res.band_lo) && (res_cnt <= res.band_hi);
        end
    end

    assign res.in_band = in_band_q;
`endif

    assign res.freq_out   = out_q;
    assign res.freq_valid = valid_q;
    assign res.overflow   = ovf_q;
    assign res.overrun    = ovr_q;
endmodule
